// File: rtl/calc_pkg.sv
// Shared constants, FSM state type and 7-segment decoding for the calculator
// display path.
package calc_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned BCD_DIGITS = 5;
    localparam int unsigned BIN_W      = 16;
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned SEG_W      = 7;

    // Segment patterns are {g,f,e,d,c,b,a}, active-low
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } conv_state_e;

    function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle,
// 16 shifts then a single LOAD cycle in which the BCD result is presented.
module bin2bcd_seq
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(BIN_W);
    localparam int unsigned SR_W  = BCD_W + BIN_W;

    conv_state_e      state;
    conv_state_e      state_nxt;
    logic [SR_W-1:0]  sr;
    logic [SR_W-1:0]  sr_adj;
    logic [CNT_W-1:0] cnt;

    // State register; busy mirrors "not IDLE" one cycle ahead so it is a flop
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (cnt == CNT_W'(BIN_W - 1)) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        done = (state == LOAD);
        bcd  = sr[SR_W-1 -: BCD_W];
    end

    // Add-3 correction on every BCD nibble that would overflow when doubled
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (sr[BIN_W + 4*i +: 4] >= 4'd5) begin
                sr_adj[BIN_W + 4*i +: 4] = sr[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift register and shift counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sr  <= {BCD_W'(0), bin};
                        cnt <= '0;
                    end
                end
                CONV: begin
                    sr  <= {sr_adj[SR_W-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/result_display.sv
// Calculator result display: converts {NEG,RESULT} to BCD on change and scans
// it onto a six-digit common-anode 7-segment display with zero blanking.
module result_display
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIN_W-1:0]      RESULT,
    input  logic                  NEG,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [SEG_W-1:0]      SEG,
    output logic                  busy
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [BIN_W:0]                 last;
    logic [BCD_DIGITS-1:0][3:0]     dig;
    logic                           sign;
    logic [SCAN_W-1:0]              scan_cnt;
    logic [2:0]                     idx;
    logic                           start;
    logic                           done;
    logic [BCD_W-1:0]               bcd;
    logic [BCD_DIGITS-1:0]          blank;
    logic                           lead_zero;

    // Only sample a new value while the converter is idle
    assign start = ({NEG, RESULT} != last) && !busy;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (RESULT),
        .bcd   (bcd),
        .done  (done),
        .busy  (busy)
    );

    // Last accepted value
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= '0;
        end else if (start) begin
            last <= {NEG, RESULT};
        end
    end

    // Displayed digits and sign; negative zero shows without a minus
    always_ff @(posedge clk) begin
        if (reset) begin
            dig  <= '0;
            sign <= 1'b0;
        end else if (done) begin
            dig  <= bcd;
            sign <= last[BIN_W] & (last[BIN_W-1:0] != '0);
        end
    end

    // Digit scan timer
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Leading-zero blanking: a digit blanks when it and everything left of it is 0
    always_comb begin
        lead_zero = 1'b1;
        blank     = '0;
        for (int i = int'(BCD_DIGITS) - 1; i >= 1; i--) begin
            lead_zero = lead_zero & (dig[i] == 4'd0);
            blank[i]  = lead_zero;
        end
    end

    // Anode select and segment mux
    always_comb begin
        AN = ~(NUM_DIGITS'(1) << idx);
        if (idx == 3'(NUM_DIGITS - 1)) begin
            SEG = sign ? SEG_MINUS : SEG_BLANK;
        end else if (blank[idx]) begin
            SEG = SEG_BLANK;
        end else begin
            SEG = seg_decode(dig[idx]);
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: a cycle-level behavioural model of value
// acceptance, conversion latency and digit scanning, compared every cycle.
module tb_result_display;

    localparam int SCAN = 4;
    localparam int CONV_CYC = 17;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] RESULT;
    logic        NEG;
    logic [5:0]  AN;
    logic [6:0]  SEG;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    int          m_t = 0;
    logic [16:0] m_last = '0;
    logic [16:0] m_pend = '0;
    int          m_busy = 0;
    int          m_val = 0;
    logic        m_sign = 1'b0;

    logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;

    result_display #(.SCAN_DIV(SCAN)) dut (
        .clk    (clk),
        .reset  (reset),
        .RESULT (RESULT),
        .NEG    (NEG),
        .AN     (AN),
        .SEG    (SEG),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cur_idx();
        return (m_t / SCAN) % 6;
    endfunction

    // Expected segments for digit k from the displayed value, by decimal arithmetic
    function automatic logic [6:0] exp_seg(input int k);
        int p;
        p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        if (k == 5) return m_sign ? MINUS : BLANK;
        if (k > 0 && m_val < p) return BLANK;
        return segtab[(m_val / p) % 10];
    endfunction

    // Model: accept on change when idle, show the value 17 cycles later
    always @(posedge clk) begin
        if (reset) begin
            m_t    <= 0;
            m_last <= '0;
            m_busy <= 0;
            m_val  <= 0;
            m_sign <= 1'b0;
        end else begin
            m_t <= m_t + 1;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_val  <= int'(m_pend[15:0]);
                    m_sign <= m_pend[16] && (m_pend[15:0] != 16'd0);
                end
            end else if ({NEG, RESULT} != m_last) begin
                m_last <= {NEG, RESULT};
                m_pend <= {NEG, RESULT};
                m_busy <= CONV_CYC;
            end
        end
    end

    // Per-cycle compare
    always @(negedge clk) begin
        if (chk_en) begin
            check("an", 32'(AN), 32'(6'(~(6'b000001 << cur_idx()))));
            check("seg", 32'(SEG), 32'(exp_seg(cur_idx())));
            check("busy", 32'(busy), 32'(m_busy != 0));
        end
    end

    task automatic apply(input int v, input bit n);
        RESULT = 16'(v);
        NEG    = n;
    endtask

    task automatic count_busy(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy === 1'b1) n++;
        end
    endtask

    task automatic show(input int k, input logic [6:0] exp);
        int n;
        n = 0;
        while (cur_idx() != k && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("show_idx", 32'(cur_idx()), 32'(k));
        check("show_an", 32'(AN), 32'(6'(~(6'b000001 << k))));
        check("show_seg", 32'(SEG), 32'(exp));
    endtask

    initial begin
        int nb;
        int r;
        reset = 1'b1;
        apply(0, 1'b0);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_an", 32'(AN), 32'(6'b111110));
        check("rst_seg", 32'(SEG), 32'(7'b1000000));
        check("rst_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        count_busy(30, nb);
        check("idle_busy_len", 32'(nb), 32'(0));

        apply(93, 1'b0);
        count_busy(40, nb);
        check("busy_len_93", 32'(nb), 32'(17));
        show(0, 7'b0110000);
        show(1, 7'b0010000);
        show(2, BLANK);
        show(3, BLANK);
        show(4, BLANK);
        show(5, BLANK);

        apply(65535, 1'b0);
        count_busy(40, nb);
        check("busy_len_65535", 32'(nb), 32'(17));
        show(0, 7'b0010010);
        show(1, 7'b0110000);
        show(2, 7'b0010010);
        show(3, 7'b0010010);
        show(4, 7'b0000010);
        show(5, BLANK);

        apply(54, 1'b1);
        count_busy(40, nb);
        check("busy_len_54", 32'(nb), 32'(17));
        show(0, 7'b0011001);
        show(1, 7'b0010010);
        show(2, BLANK);
        show(3, BLANK);
        show(4, BLANK);
        show(5, MINUS);

        apply(0, 1'b1);
        count_busy(40, nb);
        check("busy_len_negzero", 32'(nb), 32'(17));
        show(0, 7'b1000000);
        show(1, BLANK);
        show(5, BLANK);

        apply(93, 1'b0);
        repeat (5) @(negedge clk);
        apply(1234, 1'b0);
        count_busy(60, nb);
        check("busy_len_back2back", 32'(nb + 5), 32'(34));
        show(0, 7'b0011001);
        show(1, 7'b0110000);
        show(2, 7'b0100100);
        show(3, 7'b1111001);
        show(4, BLANK);

        apply(777, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        apply(0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        check("abort_an", 32'(AN), 32'(6'b111110));
        check("abort_seg", 32'(SEG), 32'(7'b1000000));
        check("abort_busy", 32'(busy), 32'(0));
        count_busy(30, nb);
        check("abort_busy_len", 32'(nb), 32'(0));
        show(0, 7'b1000000);
        show(2, BLANK);

        for (int it = 0; it < 250; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      apply(int'($urandom_range(0, 9)), 1'b0);
            else if (r < 4)  apply(int'($urandom_range(0, 999)), 1'b0);
            else             apply(int'($urandom_range(0, 65535)), 1'b0);
            NEG = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 40) == 0) reset = 1'b1;
            repeat ($urandom_range(1, 25)) @(negedge clk);
            reset = 1'b0;
        end
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
